// File: rtl/aemb2_intc.sv
// Wishbone interrupt controller for the AEMB2 sys_int_i line.
// Edge/level sources latched into ISR, masked by IER and MER.
module aemb2_intc #(
  parameter int              NIRQ = 8,
  parameter logic [NIRQ-1:0] LVL  = '0
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [NIRQ-1:0] irq_i,
  input  logic            wb_stb_i,
  input  logic            wb_wre_i,
  input  logic [2:0]      wb_adr_i,
  input  logic [3:0]      wb_sel_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            sys_int_o
);

  logic [NIRQ-1:0] isr_q, isr_d;
  logic [NIRQ-1:0] ier_q, ier_d;
  logic [NIRQ-1:0] prev_q;
  logic            mer_q, mer_d;
  logic            ack_q, ack_d;
  logic            int_q, int_d;
  logic [31:0]     dat_q, dat_d;

  logic            acc;
  logic            wr;
  logic [31:0]     lane;
  logic [31:0]     wm;
  logic [31:0]     isr_w;
  logic [31:0]     ier_w;
  logic [31:0]     ivr;
  logic [31:0]     rd;
  logic [NIRQ-1:0] pend;
  logic [NIRQ-1:0] clr;
  logic            unused_ok;

  always_comb begin
    lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
            {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wm   = wb_dat_i & lane;
    acc  = wb_stb_i & ~ack_q;
    wr   = acc & wb_wre_i;
    pend = isr_q & ier_q;

    isr_w = '0;
    isr_w[NIRQ-1:0] = isr_q;
    ier_w = '0;
    ier_w[NIRQ-1:0] = ier_q;

    // Descending scan leaves the lowest pending index.
    ivr = '1;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend[i]) ivr = 32'(i);
    end

    case (wb_adr_i)
      3'd0:    rd = isr_w;
      3'd1:    rd = ier_w;
      3'd3:    rd = ivr;
      3'd4:    rd = {31'b0, mer_q};
      default: rd = '0;
    endcase

    clr = '0;
    if (wr && wb_adr_i == 3'd2) clr = wm[NIRQ-1:0];

    ier_d = ier_q;
    if (wr && wb_adr_i == 3'd1)
      ier_d = (ier_q & ~lane[NIRQ-1:0]) | wm[NIRQ-1:0];

    mer_d = mer_q;
    if (wr && wb_adr_i == 3'd4 && wb_sel_i[0])
      mer_d = wb_dat_i[0];

    // New edge beats a same-cycle clear.
    isr_d = (LVL & irq_i)
          | (~LVL & ((isr_q & ~clr) | (irq_i & ~prev_q)));

    ack_d = acc;
    dat_d = acc ? rd : dat_q;
    int_d = mer_q & (|pend);

    unused_ok = ^wm;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      isr_q  <= '0;
      ier_q  <= '0;
      prev_q <= '0;
      mer_q  <= 1'b0;
      ack_q  <= 1'b0;
      int_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      isr_q  <= isr_d;
      ier_q  <= ier_d;
      prev_q <= irq_i;
      mer_q  <= mer_d;
      ack_q  <= ack_d;
      int_q  <= int_d;
      dat_q  <= dat_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign sys_int_o = int_q;

endmodule
